// File: rtl/kv_param_vault.sv
// kv_param_vault: key-vault storage core with round-robin write arbitration,
// a sequential per-entry scrub engine and a whole-vault debug flush.
// Optional feature: define KV_PARITY_EN to store and check one even-parity bit per dword.
module kv_param_vault #(
    parameter int unsigned NUM_KEYS   = 24,
    parameter int unsigned NUM_DWORDS = 16,
    parameter int unsigned NUM_WR     = 4,
    parameter int unsigned NUM_RD     = 8,
    parameter int unsigned DW         = 32,
    localparam int unsigned EW = $clog2(NUM_KEYS),
    localparam int unsigned OW = $clog2(NUM_DWORDS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_WR-1:0]        wr_req,
    input  logic [NUM_WR*EW-1:0]     wr_entry,
    input  logic [NUM_WR*OW-1:0]     wr_offset,
    input  logic [NUM_WR*DW-1:0]     wr_data,
    input  logic [NUM_WR*NUM_RD-1:0] wr_dest_valid,
    output logic [NUM_WR-1:0]        wr_gnt,
    output logic [NUM_WR-1:0]        wr_err,
    input  logic [NUM_RD*EW-1:0]     rd_entry,
    input  logic [NUM_RD*OW-1:0]     rd_offset,
    output logic [NUM_RD*DW-1:0]     rd_data,
    output logic [NUM_RD-1:0]        rd_last,
    output logic [NUM_RD-1:0]        rd_err,
    input  logic                     sw_we,
    input  logic [EW-1:0]            sw_entry,
    input  logic                     sw_lock_wr,
    input  logic                     sw_lock_use,
    input  logic                     sw_clear,
    input  logic                     sw_flush,
    input  logic [DW-1:0]            flush_value,
    output logic                     busy,
    output logic                     parity_err
);
    localparam int unsigned WW = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;
    localparam logic [OW-1:0] LastDw = OW'(NUM_DWORDS - 1);

    typedef enum logic [1:0] {StIdle, StScrub, StFlush} state_e;

    state_e              state_q, state_d;
    logic [DW-1:0]       mem_q [NUM_KEYS][NUM_DWORDS];
    logic [NUM_RD-1:0]   dest_q [NUM_KEYS];
    logic [OW-1:0]       last_q [NUM_KEYS];
    logic [NUM_KEYS-1:0] lock_wr_q, lock_wr_d, lock_use_q, lock_use_d, pend_q, pend_d, pend_rest;
    logic [WW-1:0]       rr_q, rr_d, gnt_idx;
    logic [OW-1:0]       cnt_q, cnt_d;
    logic [EW-1:0]       scrub_q, scrub_d, sw_idx, w_idx, w_entry;
    logic [OW-1:0]       w_offset;
    logic [DW-1:0]       w_data;
    logic [NUM_RD-1:0]   w_mask;
    logic [NUM_WR-1:0]   gnt_oh;
    logic                gnt_any, w_in_range, w_reject, w_commit, sw_in_range, clr_ok, scrub_done;
    int unsigned         cand;

    function automatic logic [EW-1:0] lowest(input logic [NUM_KEYS-1:0] v);
        logic [EW-1:0] r;
        r = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (v[i]) r = EW'(i);
        end
        return r;
    endfunction

    // Round-robin pick of one write client and rejection decode
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        gnt_oh  = '0;
        cand    = 0;
        for (int unsigned i = 0; i < NUM_WR; i++) begin
            cand = (32'(rr_q) + i) % NUM_WR;
            if (!gnt_any && wr_req[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = WW'(cand);
            end
        end
        gnt_oh[gnt_idx] = gnt_any;
        w_entry    = wr_entry[32'(gnt_idx)*EW +: EW];
        w_offset   = wr_offset[32'(gnt_idx)*OW +: OW];
        w_data     = wr_data[32'(gnt_idx)*DW +: DW];
        w_mask     = wr_dest_valid[32'(gnt_idx)*NUM_RD +: NUM_RD];
        w_in_range = 32'(w_entry) < NUM_KEYS;
        w_idx      = w_in_range ? w_entry : '0;
        // A same-cycle clear of the target entry beats the write
        w_reject   = !w_in_range || lock_wr_q[w_idx] || lock_use_q[w_idx] || pend_q[w_idx]
                     || (state_q == StScrub && scrub_q == w_entry) || (state_q == StFlush)
                     || (sw_we && sw_clear && sw_entry == w_entry);
        w_commit   = gnt_any && !w_reject && !rst;
        wr_gnt     = rst ? '0 : gnt_oh;
        wr_err     = (rst || !w_reject) ? '0 : gnt_oh;
    end

    // Control next-state: pointer, locks, pending bits and scrub/flush FSM
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        scrub_d    = scrub_q;
        pend_d     = pend_q;
        lock_wr_d  = lock_wr_q;
        lock_use_d = lock_use_q;
        rr_d       = rr_q;
        scrub_done = 1'b0;
        pend_rest  = pend_q;
        pend_rest[scrub_q] = 1'b0;
        sw_in_range = 32'(sw_entry) < NUM_KEYS;
        sw_idx      = sw_in_range ? sw_entry : '0;
        clr_ok      = sw_we && sw_clear && sw_in_range && !lock_wr_q[sw_idx] && !lock_use_q[sw_idx];
        if (gnt_any) rr_d = WW'((32'(gnt_idx) + 1) % NUM_WR);
        if (sw_we && sw_in_range) begin
            lock_wr_d[sw_idx]  = lock_wr_q[sw_idx] | sw_lock_wr;
            lock_use_d[sw_idx] = lock_use_q[sw_idx] | sw_lock_use;
        end
        unique case (state_q)
            StIdle: begin
                if (|pend_q) begin
                    state_d = StScrub;
                    scrub_d = lowest(pend_q);
                    cnt_d   = '0;
                end
            end
            StScrub: begin
                if (cnt_q == LastDw) begin
                    scrub_done = 1'b1;
                    pend_d[scrub_q] = 1'b0;
                    if (|pend_rest) begin
                        scrub_d = lowest(pend_rest);
                        cnt_d   = '0;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StFlush: begin
                if (cnt_q == LastDw) state_d = StIdle;
                else cnt_d = cnt_q + 1'b1;
            end
            default: state_d = StIdle;
        endcase
        if (clr_ok) pend_d[sw_idx] = 1'b1;
        if (state_q == StFlush) pend_d = '0;
        if (sw_flush) begin
            state_d = StFlush;
            cnt_d   = '0;
            pend_d  = '0;
        end
    end

    // Control state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            scrub_q    <= '0;
            pend_q     <= '0;
            lock_wr_q  <= '0;
            lock_use_q <= '0;
            rr_q       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            scrub_q    <= scrub_d;
            pend_q     <= pend_d;
            lock_wr_q  <= lock_wr_d;
            lock_use_q <= lock_use_d;
            rr_q       <= rr_d;
        end
    end

`ifdef KV_PARITY_EN
    logic [NUM_DWORDS-1:0] par_q [NUM_KEYS];
    logic                  parity_err_q;
    logic                  rd_par_fault;
`endif

    // Storage, per-entry metadata and parity: flush, scrub and accepted writes
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_KEYS; k++) begin
                for (int d = 0; d < NUM_DWORDS; d++) mem_q[k][d] <= '0;
                dest_q[k] <= '0;
                last_q[k] <= '0;
`ifdef KV_PARITY_EN
                par_q[k] <= '0;
`endif
            end
        end else begin
            if (state_q == StFlush) begin
                for (int k = 0; k < NUM_KEYS; k++) begin
                    mem_q[k][cnt_q] <= flush_value;
`ifdef KV_PARITY_EN
                    par_q[k][cnt_q] <= ^flush_value;
`endif
                end
            end else if (state_q == StScrub) begin
                mem_q[scrub_q][cnt_q] <= '0;
`ifdef KV_PARITY_EN
                par_q[scrub_q][cnt_q] <= 1'b0;
`endif
                if (scrub_done) begin
                    dest_q[scrub_q] <= '0;
                    last_q[scrub_q] <= '0;
                end
            end
            // Never collides with flush/scrub: those cases reject the write
            if (w_commit) begin
                mem_q[w_idx][w_offset] <= w_data;
                dest_q[w_idx]          <= w_mask;
                last_q[w_idx]          <= w_offset;
`ifdef KV_PARITY_EN
                par_q[w_idx][w_offset] <= ^w_data;
`endif
            end
        end
    end

    // Zero-latency read ports
    always_comb begin
        logic [EW-1:0] r_e, r_idx;
        logic [OW-1:0] r_o;
        logic [DW-1:0] r_word;
        logic          r_in, r_perr;
`ifdef KV_PARITY_EN
        rd_par_fault = 1'b0;
`endif
        for (int r = 0; r < NUM_RD; r++) begin
            r_e    = rd_entry[r*EW +: EW];
            r_o    = rd_offset[r*OW +: OW];
            r_in   = 32'(r_e) < NUM_KEYS;
            r_idx  = r_in ? r_e : '0;
            r_word = mem_q[r_idx][r_o];
`ifdef KV_PARITY_EN
            r_perr = r_in && ((^r_word) != par_q[r_idx][r_o]);
            rd_par_fault = rd_par_fault | r_perr;
`else
            r_perr = 1'b0;
`endif
            rd_err[r] = !r_in || lock_use_q[r_idx] || !dest_q[r_idx][r] || pend_q[r_idx]
                        || (state_q == StScrub && scrub_q == r_e) || r_perr;
            rd_data[r*DW +: DW] = rd_err[r] ? '0 : r_word;
            rd_last[r] = r_in && (r_o == last_q[r_idx]);
        end
    end

`ifdef KV_PARITY_EN
    // Sticky parity fault flag
    always_ff @(posedge clk) begin
        if (rst) parity_err_q <= 1'b0;
        else parity_err_q <= parity_err_q | rd_par_fault;
    end
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    assign busy = (state_q != StIdle);

endmodule
